// File: rtl/ascii_load_sequencer_pkg.sv
// Shared types and character constants for the ASCII load sequencer.
// States of the presenter FSM plus the control characters it filters and paces on.
package uk101_pkg;

    typedef enum logic [1:0] {IDLE, PRESENT, GAP} als_state_t;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_NUL = 8'h00;

endpackage

// File: rtl/ascii_load_sequencer_fifo.sv
// Synchronous FIFO with first-word-fall-through dout; flush empties it, a same-cycle push lands at slot 0.
// Latency: pushed word visible on dout the cycle after the push. Backpressure: push ignored when full.
// Pop ignored when empty or flushing.
module ascii_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 2**AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_addr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (flush || !full);
    assign do_pop  = pop && !flush && !empty;
    assign wr_addr = flush ? '0 : wr_ptr;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_addr] <= din;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_addr + AW'(do_push);
            rd_ptr <= (flush ? '0 : rd_ptr) + AW'(do_pop);
            count  <= (flush ? '0 : count) + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ascii_load_sequencer.sv
// Feeds a downloaded TXT file to the UK101 one paced character at a time (CR gets a long gap).
// Latency: char_valid 2 cycles after a push into an empty FIFO. Backpressure: ioctl_wait at DEPTH-2
// entries, char held until char_ready. Build option ASCII_LF_TO_CR_EN normalises CRLF/LF/CR to CR.
module ascii_load_sequencer
    import uk101_pkg::*;
#(
    parameter int FIFO_AW  = 4,
    parameter int CHAR_GAP = 50_000,
    parameter int LINE_GAP = 5_000_000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ioctl_download,
    input  logic       ioctl_wr,
    input  logic [7:0] ioctl_data,
    output logic       ioctl_wait,
    output logic       char_valid,
    output logic [7:0] char_data,
    input  logic       char_ready,
    output logic       busy,
    output logic       overflow
);
    localparam int DEPTH = 2**FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int GAP_W = $clog2(LINE_GAP + 1);

    als_state_t       state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             valid_d;
    logic [7:0]       data_d;
    logic             dl_q;
    logic             dl_rise;
    logic             keep;
    logic [7:0]       wr_byte;
    logic             push;
    logic             pop;
    logic [7:0]       fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    cnt_nxt;
    logic             fifo_full;
    logic             fifo_empty;

    assign dl_rise = ioctl_download && !dl_q;

`ifdef ASCII_LF_TO_CR_EN
    logic last_cr_q;

    // A new download must not inherit the previous file's trailing CR.
    always_comb begin
        keep    = (ioctl_data != ASCII_NUL) &&
                  !((ioctl_data == ASCII_LF) && last_cr_q && !dl_rise);
        wr_byte = (ioctl_data == ASCII_LF) ? ASCII_CR : ioctl_data;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            last_cr_q <= 1'b0;
        end else if (ioctl_wr && (ioctl_data != ASCII_NUL) && (dl_rise || !fifo_full)) begin
            last_cr_q <= (ioctl_data == ASCII_CR);
        end else if (dl_rise) begin
            last_cr_q <= 1'b0;
        end
    end
`else
    always_comb begin
        keep    = (ioctl_data != ASCII_NUL);
        wr_byte = ioctl_data;
    end
`endif

    assign push    = ioctl_wr && keep && (dl_rise || !fifo_full);
    assign cnt_nxt = (dl_rise ? '0 : fifo_count) + CW'(push) - CW'(pop);
    assign busy    = ioctl_download || !fifo_empty || (state_q != IDLE);

    ascii_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .flush   (dl_rise),
        .push    (push),
        .pop     (pop),
        .din     (wr_byte),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ioctl_wait tracks the post-edge fill level so one in-flight write still fits.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q       <= 1'b0;
            ioctl_wait <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            dl_q       <= ioctl_download;
            ioctl_wait <= (cnt_nxt >= CW'(DEPTH - 2));
            if (dl_rise) begin
                overflow <= 1'b0;
            end else if (ioctl_wr && keep && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            char_valid <= 1'b0;
            char_data  <= 8'h00;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            char_valid <= valid_d;
            char_data  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        valid_d = char_valid;
        data_d  = char_data;
        pop     = 1'b0;
        if (dl_rise) begin
            state_d = IDLE;
            gap_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = fifo_dout;
                        valid_d = 1'b1;
                        state_d = PRESENT;
                    end
                end
                PRESENT: begin
                    if (char_ready) begin
                        valid_d = 1'b0;
                        gap_d   = (char_data == ASCII_CR) ? GAP_W'(LINE_GAP) : GAP_W'(CHAR_GAP);
                        state_d = GAP;
                    end
                end
                GAP: begin
                    if (gap_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_load_sequencer.sv
// Directed and randomized bench for ascii_load_sequencer with short gaps and a 4-entry FIFO.
module tb_ascii_load_sequencer;
    localparam int CHAR_GAP = 4;
    localparam int LINE_GAP = 16;

    typedef logic [7:0] bq_t [$];

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ioctl_download = 1'b0;
    logic       ioctl_wr = 1'b0;
    logic [7:0] ioctl_data = 8'h00;
    logic       ioctl_wait;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready = 1'b0;
    logic       busy;
    logic       overflow;

    int  n_chk = 0;
    int  n_fail = 0;
    int  ncyc = 0;
    int  stab_err = 0;
    bit  rnd_rdy = 1'b0;
    bq_t acc_q;
    int  acc_t[$];
    int  rise_t[$];
    logic       pv = 1'b0;
    logic       pacc = 1'b0;
    logic [7:0] pd = 8'h00;

    ascii_load_sequencer #(.FIFO_AW(2), .CHAR_GAP(CHAR_GAP), .LINE_GAP(LINE_GAP)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .char_valid     (char_valid),
        .char_data      (char_data),
        .char_ready     (char_ready),
        .busy           (busy),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // Log handshakes and valid rises at the negedge, away from the active edge.
    always @(negedge clk_sys) begin
        ncyc++;
        if (char_valid && !pv) rise_t.push_back(ncyc);
        if (pv && !pacc && char_valid && (char_data !== pd)) stab_err++;
        if (char_valid && char_ready) begin
            acc_q.push_back(char_data);
            acc_t.push_back(ncyc);
        end
        pv   = char_valid;
        pacc = char_valid && char_ready;
        pd   = char_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (rnd_rdy) char_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_dl();
        ioctl_download = 1'b0;
        tick();
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (ioctl_wait && n < 5000) begin
            tick();
            n++;
        end
        ioctl_wr   = 1'b1;
        ioctl_data = b;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic drain(input string tag, output int t);
        int n = 0;
        while ((busy || char_valid) && n < 5000) begin
            tick();
            n++;
        end
        t = ncyc;
        chk({tag, "_drain_timeout"}, 32'(n < 5000), 1);
    endtask

    task automatic wait_acc(input string tag, input int target);
        int n = 0;
        while (acc_q.size() < target && n < 5000) begin
            tick();
            n++;
        end
        chk({tag, "_acc_timeout"}, 32'(n < 5000), 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!char_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_valid_timeout"}, 32'(n < 200), 1);
    endtask

    task automatic cmp_seq(input string tag, input int from, input bq_t exp);
        chk({tag, "_count"}, 32'(acc_q.size() - from), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (from + i < acc_q.size()) chk($sformatf("%s_char%0d", tag, i), 32'(acc_q[from + i]), 32'(exp[i]));
        end
    endtask

    task automatic check_gaps(input string tag, input int from);
        for (int i = from; i < acc_q.size(); i++) begin
            int req = (acc_q[i] == 8'h0D) ? LINE_GAP : CHAR_GAP;
            for (int j = 0; j < rise_t.size(); j++) begin
                if (rise_t[j] > acc_t[i]) begin
                    chk($sformatf("%s_gap%0d_idle%0d", tag, i, rise_t[j] - acc_t[i] - 1),
                        32'((rise_t[j] - acc_t[i] - 1) >= req), 1);
                    break;
                end
            end
        end
    endtask

    // Reference: the typed-text stream the loader should produce for a given file.
    function automatic bq_t model(input bq_t in);
        bq_t out;
        bit  last_cr = 1'b0;
        foreach (in[i]) begin
            if (in[i] == 8'h00) continue;
`ifdef ASCII_LF_TO_CR_EN
            if (in[i] == 8'h0A) begin
                if (!last_cr) out.push_back(8'h0D);
                last_cr = 1'b0;
            end else begin
                out.push_back(in[i]);
                last_cr = (in[i] == 8'h0D);
            end
`else
            out.push_back(in[i]);
`endif
        end
        return out;
    endfunction

    initial begin
        int  base;
        int  t;
        bq_t exp;
        bq_t stim;

        repeat (3) tick();
        chk("rst_valid", 32'(char_valid), 0);
        chk("rst_data", 32'(char_data), 0);
        chk("rst_wait", 32'(ioctl_wait), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        tick();

        // Reset while a character is being presented.
        start_dl();
        send(8'h51);
        wait_valid("t1");
        chk("t1_presented", 32'(char_data), 32'h51);
        reset = 1'b1;
        ioctl_download = 1'b0;
        tick();
        chk("t1_valid", 32'(char_valid), 0);
        chk("t1_data", 32'(char_data), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_overflow", 32'(overflow), 0);
        reset = 1'b0;
        tick();

        // "AB\r" with the consumer always ready.
        char_ready = 1'b1;
        base = acc_q.size();
        start_dl();
        send(8'h41);
        send(8'h42);
        send(8'h0D);
        ioctl_download = 1'b0;
        drain("t2", t);
        exp = '{8'h41, 8'h42, 8'h0D};
        cmp_seq("t2", base, exp);
        check_gaps("t2", base);
        if (acc_t.size() > 0) chk("t2_busy_after_line_gap", 32'((t - acc_t[acc_t.size() - 1]) >= LINE_GAP), 1);

        // Burst ignoring ioctl_wait while the FSM sits in a line gap.
        base = acc_q.size();
        start_dl();
        send(8'h0D);
        wait_acc("t3", base + 1);
        char_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_data = 8'(8'h61 + i);
            tick();
            chk($sformatf("t3_wait_w%0d", i), 32'(ioctl_wait), 32'(i >= 1));
            chk($sformatf("t3_ovf_w%0d", i), 32'(overflow), 32'(i >= 4));
        end
        ioctl_wr   = 1'b0;
        char_ready = 1'b1;
        wait_acc("t3", base + 5);
        exp = '{8'h0D, 8'h61, 8'h62, 8'h63, 8'h64};
        cmp_seq("t3", base, exp);
        check_gaps("t3", base);

        // New download rising edge aborts a presented 'X'.
        char_ready = 1'b0;
        send(8'h58);
        send(8'h59);
        wait_valid("t4");
        chk("t4_presented", 32'(char_data), 32'h58);
        chk("t4_ovf_sticky", 32'(overflow), 1);
        base = acc_q.size();
        ioctl_download = 1'b0;
        tick();
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b1;
        ioctl_data     = 8'h4E;
        tick();
        ioctl_wr = 1'b0;
        chk("t4_valid_dropped", 32'(char_valid), 0);
        chk("t4_ovf_cleared", 32'(overflow), 0);
        tick();
        chk("t4_new_valid", 32'(char_valid), 1);
        chk("t4_new_data", 32'(char_data), 32'h4E);
        char_ready     = 1'b1;
        ioctl_download = 1'b0;
        drain("t4", t);
        exp = '{8'h4E};
        cmp_seq("t4", base, exp);

        // NUL bytes are dropped.
        base = acc_q.size();
        start_dl();
        send(8'h00);
        send(8'h41);
        ioctl_download = 1'b0;
        drain("t5", t);
        exp = '{8'h41};
        cmp_seq("t5", base, exp);

        // Line-ending handling.
        base = acc_q.size();
        start_dl();
        stim = '{8'h41, 8'h0D, 8'h0A, 8'h42, 8'h0A, 8'h43};
        foreach (stim[i]) send(stim[i]);
        ioctl_download = 1'b0;
        drain("t6", t);
`ifdef ASCII_LF_TO_CR_EN
        exp = '{8'h41, 8'h0D, 8'h42, 8'h0D, 8'h43};
`else
        exp = '{8'h41, 8'h0D, 8'h0A, 8'h42, 8'h0A, 8'h43};
`endif
        cmp_seq("t6", base, exp);
        check_gaps("t6", base);

        // Random file with random consumer readiness.
        base = acc_q.size();
        stim.delete();
        rnd_rdy = 1'b1;
        start_dl();
        for (int i = 0; i < 40; i++) begin
            int r = int'($urandom_range(0, 9));
            logic [7:0] b;
            if (r == 0)      b = 8'h00;
            else if (r <= 2) b = 8'h0A;
            else if (r <= 4) b = 8'h0D;
            else             b = 8'(8'h41 + $urandom_range(0, 25));
            stim.push_back(b);
            send(b);
            repeat ($urandom_range(0, 2)) tick();
        end
        ioctl_download = 1'b0;
        drain("t7", t);
        rnd_rdy = 1'b0;
        cmp_seq("t7", base, model(stim));
        check_gaps("t7", base);
        chk("t7_no_overflow", 32'(overflow), 0);
        chk("stable_while_valid", 32'(stab_err), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
